// File: rtl/derivative_lag.sv
// Purpose : discrete derivative d = x[n] - x[n-L] of an unsigned sample stream, runtime lag L = 1..MAX_LAG.
// Latency : 1 clock from an accepted sample (enb=1) to d_in/valid.
// Backpress: none; enb gates acceptance, everything holds while enb=0 (valid drops), clr flushes.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   enb, clr        sample enable; synchronous flush (wins over enb, drops In)
//   In, lag_sel     unsigned sample; lag select, L = min(lag_sel+1, MAX_LAG)
//   d_in            registered two's-complement difference, DATA_W+1 bits
//   valid           one-cycle strobe, d_in holds a fully primed result
//   primed          level, history holds at least the currently selected L samples
module derivative_lag #(
  parameter int DATA_W  = 8,
  parameter int MAX_LAG = 8,
  parameter int LAG_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              clr,
  input  logic [DATA_W-1:0] In,
  input  logic [LAG_W-1:0]  lag_sel,
  output logic [DATA_W:0]   d_in,
  output logic              valid,
  output logic              primed
);

  localparam int FILL_W = $clog2(MAX_LAG + 1);
  // Common width for lag/fill comparisons; lag_sel+1 needs one extra bit.
  localparam int CW     = (LAG_W + 1 > FILL_W) ? (LAG_W + 1) : FILL_W;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PRIMING = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hist [MAX_LAG];
  logic [FILL_W-1:0]   fill, fill_nxt;
  logic [CW-1:0]       lag_req, lag_cur, lag_idx, fill_ext, fill_nxt_ext;
  logic [DATA_W-1:0]   tap;
  logic [DATA_W:0]     diff;

  // Effective lag, clamped to the history depth.
  assign lag_req = CW'(lag_sel) + CW'(1);
  assign lag_cur = (lag_req > CW'(MAX_LAG)) ? CW'(MAX_LAG) : lag_req;
  assign lag_idx = lag_cur - CW'(1);

  assign fill_nxt     = (fill == FILL_W'(MAX_LAG)) ? fill : fill + FILL_W'(1);
  assign fill_ext     = CW'(fill);
  assign fill_nxt_ext = CW'(fill_nxt);

  // Tap select as an explicit mux so the index width never has to match the array depth.
  always_comb begin
    tap = '0;
    for (int k = 0; k < MAX_LAG; k++) begin
      if (lag_idx == CW'(k)) tap = hist[k];
    end
  end

  // Zero-extended subtraction at DATA_W+1 bits cannot overflow.
  assign diff = {1'b0, In} - {1'b0, tap};

  // A change of lag lowering fill below L deasserts primed right away,
  // even before the next accepted sample moves the FSM back to PRIMING.
  assign primed = (state == RUN) && (fill_ext >= lag_cur);

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = EMPTY;
    end else if (enb) begin
      case (state)
        EMPTY:   state_nxt = (lag_cur == CW'(1)) ? RUN : PRIMING;
        PRIMING: state_nxt = (fill_nxt_ext >= lag_cur) ? RUN : PRIMING;
        RUN:     state_nxt = (fill_nxt_ext >= lag_cur) ? RUN : PRIMING;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_LAG; k++) hist[k] <= '0;
      fill  <= '0;
      d_in  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < MAX_LAG; k++) hist[k] <= '0;
      fill  <= '0;
      d_in  <= '0;
      valid <= 1'b0;
    end else if (enb) begin
      for (int k = MAX_LAG - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= In;
      fill    <= fill_nxt;
      d_in    <= diff;
      // Primed test uses the fill count before this sample is added.
      valid   <= (fill_ext >= lag_cur);
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_derivative_lag.sv
module tb_derivative_lag;
  localparam int DW = 8;
  localparam int ML = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset, enb, clr;
  logic [DW-1:0] In;
  logic [LW-1:0] lag_sel;
  logic [DW:0]   d_in;
  logic          valid, primed;

  derivative_lag #(.DATA_W(DW), .MAX_LAG(ML), .LAG_W(LW)) dut (
    .clk(clk), .reset(reset), .enb(enb), .clr(clr), .In(In),
    .lag_sel(lag_sel), .d_in(d_in), .valid(valid), .primed(primed)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: list of accepted samples since the last flush (newest at back).
  int          q[$];
  logic [DW:0] m_d;
  bit          m_v;
  int          m_last_l;

  function automatic int lag_of(input logic [LW-1:0] ls);
    int l;
    l = int'(ls) + 1;
    return (l > ML) ? ML : l;
  endfunction

  // History must cover both the lag used at the last sample and the one selected now.
  function automatic bit exp_primed();
    return (q.size() >= m_last_l) && (q.size() >= lag_of(lag_sel));
  endfunction

  task automatic model_clear();
    q.delete();
    m_d      = '0;
    m_v      = 1'b0;
    m_last_l = 1;
  endtask

  task automatic drive(input bit e, input bit c, input int x, input int ls);
    int l;
    int old;
    @(negedge clk);
    enb     = e;
    clr     = c;
    In      = x[DW-1:0];
    lag_sel = ls[LW-1:0];
    @(posedge clk);
    #1;
    if (c) begin
      model_clear();
    end else if (e) begin
      l   = lag_of(lag_sel);
      old = (q.size() >= l) ? q[q.size() - l] : 0;
      m_v = (q.size() >= l);
      m_d = 9'(x - old);
      q.push_back(x);
      if (q.size() > ML) void'(q.pop_front());
      m_last_l = l;
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enb = 1'b0; clr = 1'b0; In = '0; lag_sel = '0;
    model_clear();
    @(posedge clk); #1;
    n_cmp += 3;
    if (d_in !== 9'd0)  begin n_fail++; $display("FAIL reset_d_in got %h exp 000", d_in); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed got %b exp 0", primed); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unit_ramp();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, i, 0);
      n_cmp += 3;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL ramp%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL ramp%0d valid got %b exp %b", i, valid, m_v); end
      if (primed !== exp_primed()) begin n_fail++; $display("FAIL ramp%0d primed got %b exp %b", i, primed, exp_primed()); end
    end
    n_cmp++;
    if (d_in !== 9'd1) begin n_fail++; $display("FAIL ramp_end d_in got %h exp 001", d_in); end
  endtask

  task automatic test_lag_ramp();
    drive(0, 1, 0, 3);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 2 * i, 3);
      n_cmp += 3;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL lag4_%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL lag4_%0d valid got %b exp %b", i, valid, m_v); end
      if (primed !== exp_primed()) begin n_fail++; $display("FAIL lag4_%0d primed got %b exp %b", i, primed, exp_primed()); end
    end
    n_cmp++;
    if (d_in !== 9'd8) begin n_fail++; $display("FAIL lag4_end d_in got %h exp 008", d_in); end
  endtask

  task automatic test_extremes();
    int xs[3] = '{0, 255, 0};
    logic [DW:0] hard[3] = '{9'h000, 9'h0FF, 9'h101};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, xs[i], 0);
      n_cmp += 2;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL ext%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL ext%0d valid got %b exp %b", i, valid, m_v); end
      if (i > 0) begin
        n_cmp++;
        if (d_in !== hard[i]) begin n_fail++; $display("FAIL ext%0d_abs d_in got %h exp %h", i, d_in, hard[i]); end
      end
    end
  endtask

  task automatic test_enb_gaps();
    bit en;
    int x;
    x = 10;
    for (int i = 0; i < 7; i++) begin
      en = !(i >= 3 && i <= 5);
      drive(en, 0, en ? x : int'($urandom_range(255)), 0);
      if (en) x++;
      n_cmp += 3;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL gap%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL gap%0d valid got %b exp %b", i, valid, m_v); end
      if (primed !== exp_primed()) begin n_fail++; $display("FAIL gap%0d primed got %b exp %b", i, primed, exp_primed()); end
    end
    n_cmp++;
    if (d_in !== 9'd1) begin n_fail++; $display("FAIL gap_end d_in got %h exp 001", d_in); end
  endtask

  task automatic test_lag_increase();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) begin
      drive(1, 0, i, (i < 3) ? 0 : 7);
      n_cmp += 3;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL lagup%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL lagup%0d valid got %b exp %b", i, valid, m_v); end
      if (primed !== exp_primed()) begin n_fail++; $display("FAIL lagup%0d primed got %b exp %b", i, primed, exp_primed()); end
    end
    // Drop back to lag 2 with a full history: valid at once.
    drive(1, 0, 100, 1);
    n_cmp += 2;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL lagdown valid got %b exp 1", valid); end
    if (d_in !== 9'd89) begin n_fail++; $display("FAIL lagdown d_in got %h exp 059", d_in); end
  endtask

  task automatic test_clr();
    drive(1, 0, 20, 0);
    drive(1, 0, 30, 0);
    drive(1, 1, 50, 0);
    n_cmp += 3;
    if (d_in !== 9'd0)   begin n_fail++; $display("FAIL clr d_in got %h exp 000", d_in); end
    if (valid !== 1'b0)  begin n_fail++; $display("FAIL clr valid got %b exp 0", valid); end
    if (primed !== 1'b0) begin n_fail++; $display("FAIL clr primed got %b exp 0", primed); end
    drive(1, 0, 60, 0);
    n_cmp += 2;
    if (d_in !== 9'd60) begin n_fail++; $display("FAIL clr_first d_in got %h exp 03c", d_in); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL clr_first valid got %b exp 0", valid); end
    drive(1, 0, 65, 0);
    n_cmp += 2;
    if (d_in !== 9'd5)  begin n_fail++; $display("FAIL clr_second d_in got %h exp 005", d_in); end
    if (valid !== 1'b1) begin n_fail++; $display("FAIL clr_second valid got %b exp 1", valid); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 70, 0);
    drive(1, 0, 72, 0);
    @(negedge clk);
    enb = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp += 3;
    if (d_in !== 9'd0)   begin n_fail++; $display("FAIL areset d_in got %h exp 000", d_in); end
    if (valid !== 1'b0)  begin n_fail++; $display("FAIL areset valid got %b exp 0", valid); end
    if (primed !== 1'b0) begin n_fail++; $display("FAIL areset primed got %b exp 0", primed); end
    #1 reset = 1'b0;
    model_clear();
    drive(1, 0, 77, 2);
    n_cmp += 3;
    if (d_in !== 9'd77)  begin n_fail++; $display("FAIL areset_first d_in got %h exp 04d", d_in); end
    if (valid !== 1'b0)  begin n_fail++; $display("FAIL areset_first valid got %b exp 0", valid); end
    if (primed !== 1'b0) begin n_fail++; $display("FAIL areset_first primed got %b exp 0", primed); end
  endtask

  task automatic test_random();
    bit e, c;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(3) != 0);
      c = ($urandom_range(39) == 0);
      drive(e, c, int'($urandom_range(255)), int'($urandom_range(7)));
      n_cmp += 3;
      if (d_in !== m_d)  begin n_fail++; $display("FAIL rnd%0d d_in got %h exp %h", i, d_in, m_d); end
      if (valid !== m_v) begin n_fail++; $display("FAIL rnd%0d valid got %b exp %b", i, valid, m_v); end
      if (primed !== exp_primed()) begin n_fail++; $display("FAIL rnd%0d primed got %b exp %b", i, primed, exp_primed()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unit_ramp();
    test_lag_ramp();
    test_extremes();
    test_enb_gaps();
    test_lag_increase();
    test_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
